// File: rtl/uart_pkg.sv
// uart_pkg: shared types, register indices and STATUS bit positions for mmio_uart_tx.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_DIV = 2'd3;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 8;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-memory bus as seen by a memory-mapped responder.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [63:0] wr_data;
  logic wr_enable;
  logic rd_enable;
  logic [63:0] rd_data;
  logic hit;
  modport master(output addr, wr_data, wr_enable, rd_enable, input rd_data, hit);
  modport slave(input addr, wr_data, wr_enable, rd_enable, output rd_data, hit);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// sync_fifo: single-clock FIFO with wrap-around pointers; a push is refused whenever full at cycle start.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, status/ctrl/divisor registers.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic clk,
  input  logic rst,
  mmio_uart_tx_if.slave bus,
  output logic tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic sel_ok, wr, push, pop, full, empty, en, ovf, busy, tick;
  logic [1:0] idx;
  logic [7:0] head, shreg;
  logic [CW-1:0] count;
  logic [15:0] div, div_lat, baud;
  logic [2:0] bit_idx;
  logic [63:0] status;
  tx_state_e state;
  assign bus.hit = bus.addr >= BASE_ADDR && bus.addr < BASE_ADDR + 32'd32;
  assign sel_ok = bus.hit && bus.addr[2:0] == 3'd0;
  assign idx = bus.addr[4:3];
  assign wr = bus.wr_enable & sel_ok;
  assign push = wr && idx == OFF_TXDATA;
  assign busy = state != IDLE;
  assign pop = state == IDLE && en && !empty;
  assign tick = baud == 16'd0;
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY] = busy;
    status[ST_OVF] = ovf;
    status[ST_CNT+:8] = 8'(count);
  end
  assign bus.rd_data = !(bus.rd_enable && sel_ok) ? 64'd0 :
                       idx == OFF_STATUS ? status :
                       idx == OFF_CTRL ? {63'd0, en} :
                       idx == OFF_DIV ? {48'd0, div} : 64'd0;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(bus.wr_data[7:0]),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      en <= 1'b0;
      div <= DEFAULT_DIV;
      ovf <= 1'b0;
    end else begin
      if (push && full) ovf <= 1'b1;
      else if (wr && idx == OFF_STATUS && bus.wr_data[ST_OVF]) ovf <= 1'b0;
      if (wr && idx == OFF_CTRL) en <= bus.wr_data[0];
      if (wr && idx == OFF_DIV) div <= bus.wr_data[15:0] < 16'd2 ? 16'd2 : bus.wr_data[15:0];
    end
  end
  // div_lat freezes the bit period for the whole frame so DIVISOR writes only affect later frames
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      baud <= '0;
      bit_idx <= '0;
      shreg <= '0;
      div_lat <= '0;
    end else begin
      if (state != IDLE) baud <= tick ? div_lat - 16'd1 : baud - 16'd1;
      unique case (state)
        IDLE: if (pop) begin
          shreg <= head;
          div_lat <= div;
          baud <= div - 16'd1;
          bit_idx <= '0;
          tx <= 1'b0;
          state <= START;
        end
        START: if (tick) begin
          tx <= shreg[0];
          state <= DATA;
        end
        DATA: if (tick) begin
          tx <= bit_idx == 3'd7 ? 1'b1 : shreg[1];
          shreg <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
          state <= bit_idx == 3'd7 ? STOP : DATA;
        end
        STOP: if (tick) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus against a frame-level queue model, checked every cycle.
module tb_mmio_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  int errs = 0;
  int nchk = 0;
  mmio_uart_tx_if bus();
  mmio_uart_tx dut(.clk(clk), .rst(rst), .bus(bus), .tx(tx));
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [7:0] mq[$];
  logic line[$];
  logic m_tx = 1'b1, m_busy = 1'b0, m_en = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_div = 16'd16;

  function automatic logic m_hit(logic [31:0] a);
    return a >= 32'h1000 && a < 32'h1020;
  endfunction

  function automatic logic [63:0] m_rd(logic [31:0] a);
    logic [63:0] st;
    if (!m_hit(a) || a[2:0] != 3'd0) return 64'd0;
    st = {48'd0, 8'(mq.size()), 4'd0, m_ovf, m_busy, mq.size() == 0, mq.size() == 8};
    case (a[4:3])
      2'd1: return st;
      2'd2: return {63'd0, m_en};
      2'd3: return {48'd0, m_div};
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    int pre;
    logic [7:0] b;
    if (rst) begin
      mq.delete();
      line.delete();
      m_tx = 1'b1;
      m_busy = 1'b0;
      m_en = 1'b0;
      m_ovf = 1'b0;
      m_div = 16'd16;
    end else begin
      pre = mq.size();
      if (line.size() > 0) begin
        m_tx = line.pop_front();
        m_busy = 1'b1;
      end else if (!m_busy && m_en && pre > 0) begin
        b = mq.pop_front();
        for (int k = 0; k < 10; k++)
          for (int j = 0; j < int'(m_div); j++)
            line.push_back(k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1]);
        m_tx = line.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx = 1'b1;
        m_busy = 1'b0;
      end
      if (bus.wr_enable && m_hit(bus.addr) && bus.addr[2:0] == 3'd0)
        case (bus.addr[4:3])
          2'd0: if (pre < 8) mq.push_back(bus.wr_data[7:0]); else m_ovf = 1'b1;
          2'd1: if (bus.wr_data[3]) m_ovf = 1'b0;
          2'd2: m_en = bus.wr_data[0];
          default: m_div = bus.wr_data[15:0] < 16'd2 ? 16'd2 : bus.wr_data[15:0];
        endcase
    end
  end

  always @(negedge clk) begin
    chk("tx", {63'd0, tx}, {63'd0, m_tx});
    chk("hit", {63'd0, bus.hit}, {63'd0, m_hit(bus.addr)});
    chk("rd_data", bus.rd_data, bus.rd_enable ? m_rd(bus.addr) : 64'd0);
  end

  task automatic wr(logic [31:0] a, logic [63:0] d);
    @(posedge clk);
    #2;
    bus.addr = a;
    bus.wr_data = d;
    bus.wr_enable = 1'b1;
    @(posedge clk);
    #2;
    bus.wr_enable = 1'b0;
  endtask

  task automatic rd(logic [31:0] a, output logic [63:0] d);
    @(posedge clk);
    #2;
    bus.addr = a;
    bus.rd_enable = 1'b1;
    #4;
    d = bus.rd_data;
    bus.rd_enable = 1'b0;
  endtask

  task automatic run(logic lvl, output int n);
    n = 0;
    while (tx === lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_low();
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", {63'd0, tx}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [9:0] pat;
    int n1, n2, n3, k;
    bus.addr = 32'h0;
    bus.wr_data = 64'h0;
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    rd(32'h1008, d); chk("reset_status", d, 64'h2);
    chk("reset_tx", {63'd0, tx}, 64'd1);
    rd(32'h1018, d); chk("reset_div", d, 64'd16);
    // 0xA5 at 4 clks/bit: start, bits LSB first, stop
    pat = 10'b1101001010;
    wr(32'h1010, 64'h1);
    wr(32'h1018, 64'h4);
    wr(32'h1000, 64'hA5);
    wait_low();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 4 == 2) chk($sformatf("a5_bit%0d", c / 4), {63'd0, tx}, {63'd0, pat[c/4]});
    end
    rd(32'h1008, d); chk("post_frame_status", d, 64'h2);
    wr(32'h1010, 64'h0);
    wr(32'h1000, 64'hFF);
    for (int i = 1; i < 9; i++) wr(32'h1000, 64'(8'h10 + i));
    rd(32'h1008, d); chk("overflow_status", d, 64'h809);
    wr(32'h1008, 64'h8);
    rd(32'h1008, d); chk("overflow_cleared", d, 64'h801);
    wr(32'h1018, 64'h1);
    rd(32'h1018, d); chk("div_min", d, 64'h2);
    wr(32'h1018, 64'h4);
    wr(32'h1010, 64'h1);
    wait_low();
    run(1'b0, n1);
    fork
      run(1'b1, n2);
      wr(32'h1018, 64'h8);
    join
    run(1'b0, n3);
    chk("f1_start_len", 64'(n1), 64'd4);
    chk("f1_high_len", 64'(n2), 64'd37);
    chk("f2_start_len", 64'(n3), 64'd8);
    k = 0;
    d = 64'h0;
    while (d != 64'h2 && k < 2000) begin
      rd(32'h1008, d);
      k++;
    end
    chk("drained", d, 64'h2);
    wr(32'h1018, 64'h4);
    for (int i = 0; i < 4; i++) wr(32'h1000, 64'(8'h30 + i));
    repeat (2) @(posedge clk);
    rd(32'h1008, d); chk("pre_rst_status", d, 64'h304);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_tx", {63'd0, tx}, 64'd1);
    rd(32'h1008, d); chk("rst_status", d, 64'h2);
    repeat (60) @(posedge clk);
    #2 chk("rst_no_frames", {63'd0, tx}, 64'd1);
    wr(32'h1004, 64'h55);
    wr(32'h2000, 64'h55);
    rd(32'h1004, d); chk("rd_unaligned", d, 64'h0);
    rd(32'h2000, d); chk("rd_miss", d, 64'h0);
    chk("hit_2000", {63'd0, bus.hit}, 64'd0);
    rd(32'h1008, d); chk("no_push_status", d, 64'h2);
    bus.addr = 32'h101F;
    #1 chk("hit_top", {63'd0, bus.hit}, 64'd1);
    bus.addr = 32'h1020;
    #1 chk("hit_past", {63'd0, bus.hit}, 64'd0);
    bus.addr = 32'h0FFF;
    #1 chk("hit_below", {63'd0, bus.hit}, 64'd0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
